// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: N-digit packed-BCD count-down timer with start/pause/resume,
// load with per-nibble clamping to 9, and a one-cycle expiry pulse.
// Optional feature: define BCD_TIMER_AUTORELOAD_EN to reload from the last loaded
// value on expiry, instead of stopping in DONE.
module bcd_countdown_timer #(
  parameter int                  DIGITS      = 2,
  parameter int                  CLOCK_FREQ  = 50000000,
  parameter int                  TICK_HZ     = 1,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 'h60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  expired,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int P  = CLOCK_FREQ / TICK_HZ;
  localparam int PW = $clog2(P);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [W-1:0]  ONE    = W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  digits_q, digits_d;
  logic [W-1:0]  reload_q, reload_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d;

  // Any nibble above 9 is not a BCD digit; saturate it to 9.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // Decrement by one with a BCD borrow chain: a 0 digit wraps to 9 and borrows upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, count and prescaler logic; load overrides everything else.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    if (load) begin
      digits_d = clamp_bcd(load_value);
      reload_d = clamp_bcd(load_value);
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            presc_d = '0;
            if (digits_q == '0) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // The cycle in which pause is sampled is still a counted RUN cycle;
          // the prescaler then holds while PAUSED.
          presc_d = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
          if (pause) begin
            state_d = ST_PAUSED;
          end
          if (presc_q == P_LAST) begin
            if (digits_q == ONE) begin
              expired_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
              if (reload_q != '0) begin
                digits_d = reload_q;
              end else begin
                digits_d = '0;
                state_d  = ST_DONE;
              end
`else
              digits_d = '0;
              state_d  = ST_DONE;
`endif
            end else begin
              digits_d = bcd_dec(digits_q);
            end
          end
        end
        ST_PAUSED: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, count and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digits_q  <= RESET_VALUE;
      reload_q  <= RESET_VALUE;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer (DIGITS=2, P=10, RESET_VALUE='h60).
// A decimal-arithmetic model is compared against the DUT on every falling edge,
// and directed steps pin hand-computed values. BCD_TIMER_AUTORELOAD_EN selects
// the autoreload scenario and model behaviour.
module tb_bcd_countdown_timer;

  localparam int P = 10;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  typedef struct {
    int mode;
    int cnt;
    int rel;
    int ph;
    bit ex;
  } mstate_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic [7:0] digits;
  logic       running;
  logic       expired;
  logic       done;

  int      total = 0;
  int      bad   = 0;
  mstate_t ms;

  bcd_countdown_timer #(
    .DIGITS(2),
    .CLOCK_FREQ(10),
    .TICK_HZ(1),
    .RESET_VALUE(8'h60)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .digits(digits),
    .running(running),
    .expired(expired),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word with each nibble saturated at 9.
  function automatic int clamp_val(input logic [7:0] v);
    int lo;
    int hi;
    lo = int'(v[3:0]);
    hi = int'(v[7:4]);
    if (lo > 9) lo = 9;
    if (hi > 9) hi = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r;
    r = 32'(((n / 10) % 10) * 16 + (n % 10));
    return r;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r.mode = M_IDLE;
    r.cnt  = 60;
    r.rel  = 60;
    r.ph   = 0;
    r.ex   = 1'b0;
    return r;
  endfunction

  // One clock of the timer rules, in plain decimal arithmetic.
  function automatic mstate_t model_next(input mstate_t s, input logic ld, input logic [7:0] lv,
                                         input logic st, input logic pa);
    mstate_t n;
    n    = s;
    n.ex = 1'b0;
    if (ld) begin
      n.cnt  = clamp_val(lv);
      n.rel  = n.cnt;
      n.ph   = 0;
      n.mode = M_IDLE;
    end else if (s.mode == M_IDLE) begin
      if (st) begin
        if (s.cnt == 0) begin
          n.mode = M_DONE;
          n.ex   = 1'b1;
        end else begin
          n.mode = M_RUN;
          n.ph   = 0;
        end
      end
    end else if (s.mode == M_RUN) begin
      n.ph = s.ph + 1;
      if (n.ph == P) begin
        n.ph  = 0;
        n.cnt = s.cnt - 1;
        if (n.cnt == 0) begin
          n.ex = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
          if (s.rel != 0) n.cnt = s.rel;
          else n.mode = M_DONE;
`else
          n.mode = M_DONE;
`endif
        end
      end
      if (pa && n.mode == M_RUN) n.mode = M_PAUSED;
    end else if (s.mode == M_PAUSED) begin
      if (st) n.mode = M_RUN;
    end
    return n;
  endfunction

  // Reference model state, reset asynchronously like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= model_reset();
    else ms <= model_next(ms, load, load_value, start, pause);
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("m_digits", 32'(digits), to_bcd(ms.cnt));
    check("m_running", 32'(running), 32'(ms.mode == M_RUN));
    check("m_done", 32'(done), 32'(ms.mode == M_DONE));
    check("m_expired", 32'(expired), 32'(ms.ex));
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load_value = v;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    load       = 1'b0;
    load_value = 8'h00;
    start      = 1'b0;
    pause      = 1'b0;
    #2 rst_n = 1'b0;
    wait_n(3);
    check("rst_digits", 32'(digits), 32'h60);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_expired", 32'(expired), 32'h0);
    rst_n = 1'b1;
    wait_n(1);

    // Reset value and BCD borrow 60 -> 59
    pulse_start();
    check("run_entry", 32'(running), 32'h1);
    wait_n(9);
    check("pre_tick_60", 32'(digits), 32'h60);
    wait_n(1);
    check("borrow_59", 32'(digits), 32'h59);

    // Run to expiry from 03
    pulse_load(8'h03);
    check("load_03", 32'(digits), 32'h03);
    check("load_idle", 32'(running), 32'h0);
    pulse_start();
    wait_n(10);
    check("exp_02", 32'(digits), 32'h02);
    wait_n(10);
    check("exp_01", 32'(digits), 32'h01);
    wait_n(9);
    check("exp_pre", 32'(expired), 32'h0);
    wait_n(1);
    check("exp_00", 32'(digits), 32'h00);
    check("exp_pulse", 32'(expired), 32'h1);
    check("exp_done", 32'(done), 32'h1);
    wait_n(1);
    check("exp_one_cycle", 32'(expired), 32'h0);
    pulse_start();
    wait_n(3);
    check("done_holds", 32'(done), 32'h1);

    // Pause after 4 RUN cycles, hold 50, resume
    pulse_load(8'h05);
    pulse_start();
    wait_n(3);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("paused", 32'(running), 32'h0);
    wait_n(50);
    check("paused_hold", 32'(digits), 32'h05);
    pulse_start();
    wait_n(5);
    check("resume_05", 32'(digits), 32'h05);
    wait_n(1);
    check("resume_04", 32'(digits), 32'h04);

    // Load mid-run with clamping; start/pause in the same cycle are ignored
    wait_n(3);
    load_value = 8'hA7;
    load  = 1'b1;
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    check("clamp_97", 32'(digits), 32'h97);
    check("load_to_idle", 32'(running), 32'h0);
    pulse_start();
    wait_n(9);
    check("presc_clear_97", 32'(digits), 32'h97);
    wait_n(1);
    check("presc_clear_96", 32'(digits), 32'h96);
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    check("run_pause_wins", 32'(running), 32'h0);
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    check("paused_start_wins", 32'(running), 32'h1);

    // Zero start, then asynchronous reset between edges
    pulse_load(8'h00);
    pulse_start();
    check("zero_expired", 32'(expired), 32'h1);
    check("zero_done", 32'(done), 32'h1);
    check("zero_digits", 32'(digits), 32'h00);
    wait_n(1);
    check("zero_exp_clear", 32'(expired), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits), 32'h60);
    check("arst_done", 32'(done), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_expired", 32'(expired), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(1);

`ifdef BCD_TIMER_AUTORELOAD_EN
    // Autoreload from 02: expiry every 20 cycles
    pulse_load(8'h02);
    pulse_start();
    wait_n(10);
    check("ar_01", 32'(digits), 32'h01);
    wait_n(9);
    check("ar_pre", 32'(expired), 32'h0);
    wait_n(1);
    check("ar_exp1", 32'(expired), 32'h1);
    check("ar_reload1", 32'(digits), 32'h02);
    check("ar_not_done1", 32'(done), 32'h0);
    wait_n(1);
    check("ar_exp1_clear", 32'(expired), 32'h0);
    wait_n(19);
    check("ar_exp2", 32'(expired), 32'h1);
    check("ar_reload2", 32'(digits), 32'h02);
    check("ar_not_done2", 32'(done), 32'h0);
    check("ar_running", 32'(running), 32'h1);
`endif

    wait_n(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised N-digit BCD count-down timer for game-time keeping. It is the successor to the fixed two-digit game timer and adds a configurable digit count, tick rate and reset value, plus start/pause/resume control and an expiry indication. It sits between the game-control FSM, which drives load/start/pause and watches `expired`, and the seven-segment display path, which consumes `digits`.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD digits, valid range 1..8; digit 0 is the least significant.
- `CLOCK_FREQ`, 50000000: `clk` frequency in Hz.
- `TICK_HZ`, 1: decrement rate. Tick period is P = CLOCK_FREQ/TICK_HZ cycles, which must be ≥ 2.
- `RESET_VALUE`, 'h60: packed BCD value of `digits` after reset, 4*DIGITS bits wide.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load`  in  1  one-cycle request to load `load_value`.
- `load_value`  in  4*DIGITS  packed BCD load value.
- `start`  in  1  start or resume counting.
- `pause`  in  1  pause counting.
- `digits`  out  4*DIGITS  current packed BCD count.
- `running`  out  1  high while in RUN.
- `expired`  out  1  one-cycle pulse when the count reaches zero.
- `done`  out  1  high while in DONE.

## Operation
- States are IDLE, RUN, PAUSED and DONE.
- Reset values: state IDLE, `digits` = RESET_VALUE, prescaler 0, reload register = RESET_VALUE, `running` 0, `expired` 0, `done` 0.
- `load` has top priority in every state:
  - `digits` and the reload register take `load_value`; any nibble > 9 is clamped to 9.
  - The prescaler clears and the state goes to IDLE.
  - `start` and `pause` are ignored in that cycle.
- IDLE:
  - `start` with nonzero `digits` → RUN.
  - `start` with `digits` = 0 → DONE, and `expired` pulses on the same edge.
  - `pause` is ignored.
- RUN:
  - The prescaler counts 0..P-1 and wraps. A tick is the cycle in which prescaler = P-1.
  - On a tick, `digits` decrements by one using a BCD borrow chain: a digit equal to 0 becomes 9 and borrows from the next digit.
  - A tick that takes `digits` from 1 to 0 moves the state to DONE and pulses `expired`.
  - `pause` → PAUSED, and the prescaler holds its value (it is not cleared). `start` is ignored.
- PAUSED:
  - `start` → RUN, and the prescaler resumes from its held value.
  - `pause` is ignored.
- DONE: `digits` holds 0. `start` and `pause` are ignored; only `load` or reset leaves DONE.
- `start` and `pause` asserted together: in RUN, pause wins; in IDLE or PAUSED, start wins.
- Asserting `rst_n` in any state returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- `digits` reflects a load on the edge after `load` is sampled.
- The k-th decrement lands exactly k·P RUN-state cycles after the edge on which the state entered RUN. Cycles spent in PAUSED do not count.
- `expired` is high for exactly one cycle: the cycle in which `digits` first reads 0 and `done` first reads 1.
- `running` and `done` change on the same edge as the state.

## Configuration
- Macro: `BCD_TIMER_AUTORELOAD_EN`.
- When defined:
  - The terminal tick does not enter DONE. Instead `digits` reloads from the reload register, the state stays in RUN, and the prescaler continues wrapping.
  - `expired` pulses once per period, in the cycle in which the reloaded value appears.
  - A zero reload register is an exception: the block enters DONE as in the undefined case.
- When undefined: the block stops in DONE as described in Operation.

## Test plan
All scenarios use CLOCK_FREQ=10, TICK_HZ=1 (P=10), DIGITS=2, RESET_VALUE='h60.
- Reset and BCD borrow: release `rst_n`, then pulse `start`. `digits` must read 'h60 until 10 cycles after entering RUN, then read 'h59.
- Run to expiry: load 'h03, start. `digits` must step 'h02, 'h01, 'h00 at cycles 10, 20 and 30. At cycle 30 `expired` is high for one cycle and `done` goes high and stays high.
- Pause/resume: load 'h05, start, pause after 4 cycles, hold PAUSED for 50 cycles, then start. The first decrement to 'h04 must occur 6 cycles after resume.
- Load mid-run and clamping: while in RUN, load 'hA7. `digits` must read 'h97, state must be IDLE and the prescaler 0. Check that `start` and `pause` asserted in the same cycle as `load` are ignored.
- Zero start and asynchronous reset: load 'h00 and pulse `start`. `expired` must pulse and `done` must assert on that edge. Then drop `rst_n` between clock edges: outputs must return to reset values immediately.
- Autoreload, with `BCD_TIMER_AUTORELOAD_EN` defined: load 'h02, start. `expired` must pulse at cycles 20 and 40, with `digits` reading 'h02 after each pulse and `done` staying low.
